// File: rtl/datapath_input_seq.sv
// SCSI-side input datapath steering sequencer: lane enables, bridge select,
// upper-word strobe and per-half load pulses for WORD/PACK/BRIDGE transfers.
// Ports: SCLK, RST (sync, active-high); REQ/MODE/SRC_ACK requests and handshake;
// bDIEH/bDIEL/bBRIDGEIN/BnDS_O_ steering; LOAD_HI/LOAD_LO/BUSY/DONE/ERR status.
// Optional macro ACK_TIMEOUT_EN: abort a wait state after TMO_MAX cycles.
module datapath_input_seq #(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input  logic       SCLK,
  input  logic       RST,
  input  logic       REQ,
  input  logic [1:0] MODE,
  input  logic       SRC_ACK,
  output logic       bDIEH,
  output logic       bDIEL,
  output logic       bBRIDGEIN,
  output logic       BnDS_O_,
  output logic       LOAD_HI,
  output logic       LOAD_LO,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  if (TMO_MAX < 1 || TMO_MAX >= (1 << TMO_W)) begin : g_tmo_chk
    $error("TMO_MAX does not fit in TMO_W bits");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_HI_EN, S_HI_CAP, S_LO_EN, S_LO_CAP,
    S_BR_STB, S_BR_REL, S_BR_EN, S_BR_CAP, S_FIN
  } state_t;

  state_t state_q, state_d;
  logic   err_q, err_d;

  logic dieh_q, dieh_d;
  logic diel_q, diel_d;
  logic brin_q, brin_d;
  logic nds_q, nds_d;
  logic ldhi_q, ldhi_d;
  logic ldlo_q, ldlo_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic erro_q, erro_d;

`ifdef ACK_TIMEOUT_EN
  logic [TMO_W-1:0] cnt_q, cnt_d;
  logic             tmo;
  assign tmo = (cnt_q == TMO_W'(TMO_MAX - 1));
`endif

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (REQ) begin
          unique case (MODE)
            2'b00: state_d = S_LO_EN;
            2'b01: state_d = S_HI_EN;
            2'b10: state_d = S_BR_STB;
            default: begin
              state_d = S_FIN;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_HI_EN: begin
        if (SRC_ACK) state_d = S_HI_CAP;
`ifdef ACK_TIMEOUT_EN
        else if (tmo) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end
`endif
      end
      S_HI_CAP: state_d = S_LO_EN;
      S_LO_EN: begin
        if (SRC_ACK) state_d = S_LO_CAP;
`ifdef ACK_TIMEOUT_EN
        else if (tmo) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end
`endif
      end
      S_LO_CAP: state_d = S_FIN;
      S_BR_STB: begin
        if (SRC_ACK) state_d = S_BR_REL;
`ifdef ACK_TIMEOUT_EN
        else if (tmo) begin
          state_d = S_FIN;
          err_d   = 1'b1;
        end
`endif
      end
      S_BR_REL: state_d = S_BR_EN;
      S_BR_EN:  state_d = S_BR_CAP;
      S_BR_CAP: state_d = S_FIN;
      S_FIN: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
    endcase
`ifdef ACK_TIMEOUT_EN
    // Restart the count on every state change, so each wait state
    // starts from zero on entry.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
`endif
  end

  // Outputs decode the next state so they line up with the state register.
  always_comb begin
    dieh_d = (state_d == S_HI_EN) || (state_d == S_HI_CAP);
    diel_d = (state_d == S_LO_EN) || (state_d == S_LO_CAP);
    brin_d = (state_d == S_BR_EN) || (state_d == S_BR_CAP);
    nds_d  = (state_d != S_BR_STB);
    ldhi_d = (state_d == S_HI_CAP);
    ldlo_d = (state_d == S_LO_CAP) || (state_d == S_BR_CAP);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
    erro_d = (state_d == S_FIN) && err_d;
  end

  always_ff @(posedge SCLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      err_q   <= 1'b0;
      dieh_q  <= 1'b0;
      diel_q  <= 1'b0;
      brin_q  <= 1'b0;
      nds_q   <= 1'b1;
      ldhi_q  <= 1'b0;
      ldlo_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      erro_q  <= 1'b0;
`ifdef ACK_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      dieh_q  <= dieh_d;
      diel_q  <= diel_d;
      brin_q  <= brin_d;
      nds_q   <= nds_d;
      ldhi_q  <= ldhi_d;
      ldlo_q  <= ldlo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      erro_q  <= erro_d;
`ifdef ACK_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign bDIEH     = dieh_q;
  assign bDIEL     = diel_q;
  assign bBRIDGEIN = brin_q;
  assign BnDS_O_   = nds_q;
  assign LOAD_HI   = ldhi_q;
  assign LOAD_LO   = ldlo_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR       = erro_q;

endmodule

// File: tb/tb_datapath_input_seq.sv
// Testbench for datapath_input_seq: per-cycle expected output vectors
// queued at drive time and compared at the falling edge.
module tb_datapath_input_seq;

  logic       SCLK;
  logic       RST;
  logic       REQ;
  logic [1:0] MODE;
  logic       SRC_ACK;
  logic       bDIEH, bDIEL, bBRIDGEIN, BnDS_O_;
  logic       LOAD_HI, LOAD_LO, BUSY, DONE, ERR;

  datapath_input_seq #(.TMO_W(8), .TMO_MAX(4)) dut (
    .SCLK(SCLK), .RST(RST), .REQ(REQ), .MODE(MODE), .SRC_ACK(SRC_ACK),
    .bDIEH(bDIEH), .bDIEL(bDIEL), .bBRIDGEIN(bBRIDGEIN), .BnDS_O_(BnDS_O_),
    .LOAD_HI(LOAD_HI), .LOAD_LO(LOAD_LO), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  // {dh, dl, br, nds, ldhi, ldlo, busy, done, err}
  localparam logic [8:0] E_IDLE   = 9'b000100000;
  localparam logic [8:0] E_HI_EN  = 9'b100100100;
  localparam logic [8:0] E_HI_CAP = 9'b100110100;
  localparam logic [8:0] E_LO_EN  = 9'b010100100;
  localparam logic [8:0] E_LO_CAP = 9'b010101100;
  localparam logic [8:0] E_BR_STB = 9'b000000100;
  localparam logic [8:0] E_BR_REL = 9'b000100100;
  localparam logic [8:0] E_BR_EN  = 9'b001100100;
  localparam logic [8:0] E_BR_CAP = 9'b001101100;
  localparam logic [8:0] E_FIN    = 9'b000100110;
  localparam logic [8:0] E_FINERR = 9'b000100111;

  typedef struct packed {
    logic       rst;
    logic       req;
    logic [1:0] mode;
    logic       ack;
    logic [8:0] exp;
  } row_t;

  logic [8:0] outs;
  assign outs = {bDIEH, bDIEL, bBRIDGEIN, BnDS_O_, LOAD_HI, LOAD_LO,
                 BUSY, DONE, ERR};

  logic [8:0] sb[$];
  int checks = 0;
  int errors = 0;

  // Source data and the external upper-word latch clocked by BnDS_O_.
  logic [31:0] data = 32'h0000_1234;
  logic [15:0] upper_l;
  logic [15:0] id_lo;
  always @(posedge BnDS_O_) upper_l = data[31:16];
  assign id_lo = bBRIDGEIN ? upper_l : (bDIEL ? data[15:0] : 16'h0000);

  function automatic row_t r(input logic rs, input logic rq,
                             input logic [1:0] m, input logic a,
                             input logic [8:0] e);
    row_t x;
    x.rst = rs; x.req = rq; x.mode = m; x.ack = a; x.exp = e;
    return x;
  endfunction

  task automatic drive(input row_t rw);
    RST = rw.rst;
    REQ = rw.req;
    MODE = rw.mode;
    SRC_ACK = rw.ack;
    sb.push_back(rw.exp);
  endtask

  task automatic test_reset;
    row_t rows[$];
    logic [8:0] e;
    rows.push_back(r(1, 1, 2'b01, 1, E_IDLE));
    rows.push_back(r(1, 1, 2'b10, 1, E_IDLE));
    rows.push_back(r(0, 0, 2'b00, 0, E_IDLE));
    rows.push_back(r(0, 0, 2'b00, 1, E_IDLE));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge SCLK);
      e = sb.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL reset c%0d: got %b want %b", i, outs, e);
      end
      @(posedge SCLK); #1;
    end
  endtask

  task automatic test_word;
    row_t rows[$];
    logic [8:0] e;
    rows.push_back(r(0, 1, 2'b00, 0, E_IDLE));
    rows.push_back(r(0, 0, 2'b00, 0, E_LO_EN));
    rows.push_back(r(0, 0, 2'b00, 0, E_LO_EN));
    rows.push_back(r(0, 0, 2'b00, 1, E_LO_EN));
    rows.push_back(r(0, 0, 2'b00, 0, E_LO_CAP));
    rows.push_back(r(0, 0, 2'b00, 1, E_FIN));
    rows.push_back(r(0, 0, 2'b00, 1, E_IDLE));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge SCLK);
      e = sb.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL word c%0d: got %b want %b", i, outs, e);
      end
      @(posedge SCLK); #1;
    end
  endtask

  task automatic test_pack;
    row_t rows[$];
    logic [8:0] e;
    rows.push_back(r(0, 1, 2'b01, 0, E_IDLE));
    rows.push_back(r(0, 0, 2'b01, 1, E_HI_EN));
    rows.push_back(r(0, 0, 2'b01, 0, E_HI_CAP));
    rows.push_back(r(0, 0, 2'b01, 1, E_LO_EN));
    rows.push_back(r(0, 0, 2'b01, 0, E_LO_CAP));
    rows.push_back(r(0, 0, 2'b01, 0, E_FIN));
    rows.push_back(r(0, 0, 2'b01, 0, E_IDLE));
    // Held ack: each wait state still costs exactly one cycle.
    rows.push_back(r(0, 1, 2'b01, 1, E_IDLE));
    rows.push_back(r(0, 0, 2'b01, 1, E_HI_EN));
    rows.push_back(r(0, 0, 2'b01, 1, E_HI_CAP));
    rows.push_back(r(0, 0, 2'b01, 1, E_LO_EN));
    rows.push_back(r(0, 0, 2'b01, 1, E_LO_CAP));
    rows.push_back(r(0, 0, 2'b01, 1, E_FIN));
    rows.push_back(r(0, 0, 2'b01, 1, E_IDLE));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge SCLK);
      e = sb.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL pack c%0d: got %b want %b", i, outs, e);
      end
      @(posedge SCLK); #1;
    end
  endtask

  task automatic test_bridge;
    row_t rows[$];
    logic [8:0] e;
    data = 32'hA5A5_1234;
    rows.push_back(r(0, 1, 2'b10, 0, E_IDLE));
    rows.push_back(r(0, 0, 2'b10, 1, E_BR_STB));
    rows.push_back(r(0, 0, 2'b10, 0, E_BR_REL));
    rows.push_back(r(0, 0, 2'b10, 0, E_BR_EN));
    rows.push_back(r(0, 0, 2'b10, 0, E_BR_CAP));
    rows.push_back(r(0, 0, 2'b10, 0, E_FIN));
    rows.push_back(r(0, 0, 2'b10, 0, E_IDLE));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge SCLK);
      e = sb.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL bridge c%0d: got %b want %b", i, outs, e);
      end
      if (i == 4) begin
        checks++;
        if (id_lo !== 16'hA5A5) begin
          errors++;
          $display("FAIL bridge_id: got %h want a5a5", id_lo);
        end
      end
      @(posedge SCLK); #1;
    end
    data = 32'h0000_1234;
  endtask

  task automatic test_back_to_back;
    row_t rows[$];
    logic [8:0] e;
    rows.push_back(r(0, 1, 2'b11, 0, E_IDLE));
    rows.push_back(r(0, 1, 2'b11, 0, E_FINERR));
    rows.push_back(r(0, 1, 2'b11, 0, E_IDLE));
    rows.push_back(r(0, 1, 2'b00, 1, E_FINERR));
    rows.push_back(r(0, 1, 2'b00, 1, E_IDLE));
    rows.push_back(r(0, 1, 2'b00, 1, E_LO_EN));
    rows.push_back(r(0, 1, 2'b00, 1, E_LO_CAP));
    rows.push_back(r(0, 1, 2'b01, 1, E_FIN));
    rows.push_back(r(0, 0, 2'b01, 1, E_IDLE));
    rows.push_back(r(0, 0, 2'b00, 0, E_IDLE));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge SCLK);
      e = sb.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL b2b c%0d: got %b want %b", i, outs, e);
      end
      @(posedge SCLK); #1;
    end
  endtask

  task automatic test_reset_midop;
    row_t rows[$];
    logic [8:0] e;
    rows.push_back(r(0, 1, 2'b01, 0, E_IDLE));
    rows.push_back(r(0, 0, 2'b01, 1, E_HI_EN));
    rows.push_back(r(0, 0, 2'b01, 0, E_HI_CAP));
    rows.push_back(r(1, 0, 2'b01, 0, E_LO_EN));
    rows.push_back(r(0, 0, 2'b01, 1, E_IDLE));
    rows.push_back(r(0, 0, 2'b01, 0, E_IDLE));
    rows.push_back(r(0, 1, 2'b10, 0, E_IDLE));
    rows.push_back(r(1, 0, 2'b10, 0, E_BR_STB));
    rows.push_back(r(0, 0, 2'b10, 1, E_IDLE));
    rows.push_back(r(0, 0, 2'b00, 0, E_IDLE));
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge SCLK);
      e = sb.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL rst_midop c%0d: got %b want %b", i, outs, e);
      end
      @(posedge SCLK); #1;
    end
  endtask

  task automatic test_ack_wait;
    row_t rows[$];
    logic [8:0] e;
    rows.push_back(r(0, 1, 2'b00, 0, E_IDLE));
    rows.push_back(r(0, 0, 2'b00, 0, E_LO_EN));
    rows.push_back(r(0, 0, 2'b00, 0, E_LO_EN));
    rows.push_back(r(0, 0, 2'b00, 0, E_LO_EN));
`ifdef ACK_TIMEOUT_EN
    rows.push_back(r(0, 0, 2'b00, 0, E_LO_EN));
    rows.push_back(r(0, 0, 2'b00, 0, E_FINERR));
    rows.push_back(r(0, 0, 2'b00, 0, E_IDLE));
    rows.push_back(r(0, 1, 2'b00, 0, E_IDLE));
    rows.push_back(r(0, 0, 2'b00, 0, E_LO_EN));
    rows.push_back(r(0, 0, 2'b00, 0, E_LO_EN));
    rows.push_back(r(0, 0, 2'b00, 0, E_LO_EN));
    rows.push_back(r(0, 0, 2'b00, 1, E_LO_EN));
    rows.push_back(r(0, 0, 2'b00, 0, E_LO_CAP));
    rows.push_back(r(0, 0, 2'b00, 0, E_FIN));
    rows.push_back(r(0, 0, 2'b00, 0, E_IDLE));
`else
    for (int k = 0; k < 8; k++)
      rows.push_back(r(0, 0, 2'b00, 0, E_LO_EN));
    rows.push_back(r(0, 0, 2'b00, 1, E_LO_EN));
    rows.push_back(r(0, 0, 2'b00, 0, E_LO_CAP));
    rows.push_back(r(0, 0, 2'b00, 0, E_FIN));
    rows.push_back(r(0, 0, 2'b00, 0, E_IDLE));
`endif
    foreach (rows[i]) begin
      drive(rows[i]);
      @(negedge SCLK);
      e = sb.pop_front();
      checks++;
      if (outs !== e) begin
        errors++;
        $display("FAIL ack_wait c%0d: got %b want %b", i, outs, e);
      end
      @(posedge SCLK); #1;
    end
  endtask

  task automatic test_random_invariants;
    int bad;
    bit idle_seen;
    RST = 1'b0;
    bad = 0;
    for (int n = 0; n < 10000; n++) begin
      REQ = ($urandom_range(0, 3) == 0);
      MODE = 2'($urandom_range(0, 3));
      SRC_ACK = ($urandom_range(0, 2) == 0);
      @(negedge SCLK);
      if ((bDIEL && bBRIDGEIN) || (LOAD_HI && !bDIEH) ||
          (LOAD_LO && !(bDIEL || bBRIDGEIN)) ||
          (!BnDS_O_ && (!BUSY || bDIEH || bDIEL || bBRIDGEIN)) ||
          (ERR && !DONE) || (DONE && !BUSY) ||
          (bDIEH && bDIEL)) begin
        bad++;
        if (bad <= 5)
          $display("FAIL invariant n%0d: got %b", n, outs);
      end
      @(posedge SCLK); #1;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL invariants: got %0d bad cycles want 0", bad);
    end
    REQ = 1'b0;
    SRC_ACK = 1'b1;
    idle_seen = 1'b0;
    for (int n = 0; n < 20 && !idle_seen; n++) begin
      @(negedge SCLK);
      if (!BUSY) idle_seen = 1'b1;
      @(posedge SCLK); #1;
    end
    checks++;
    if (!idle_seen) begin
      errors++;
      $display("FAIL drain: got busy want idle within 20 cycles");
    end
    SRC_ACK = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    REQ = 1'b0;
    MODE = 2'b00;
    SRC_ACK = 1'b0;
    @(posedge SCLK); #1;
    test_reset;
    test_word;
    test_pack;
    test_bridge;
    test_back_to_back;
    test_reset_midop;
    test_ack_wait;
    test_random_invariants;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
